// File: rtl/rv32i_types.sv
// Shared RV32I type definitions used across the cache and memory interface.
package rv32i_types;

    typedef logic [255:0] rv32i_cacheline;
    typedef logic [63:0]  rv32i_burst;

    localparam int unsigned BURST_BEATS = 4;

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts single-transfer cache line reads/writebacks into multi-beat memory bursts.
module cacheline_adaptor
    import rv32i_types::*;
#(
    parameter int unsigned LINE_W  = $bits(rv32i_cacheline),
    parameter int unsigned BURST_W = $bits(rv32i_burst)
) (
    input  logic               clk,
    input  logic               rst_n,

    // Cache side
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,

    // Memory side
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    localparam int unsigned BEATS = LINE_W / BURST_W;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned OFF_W = $clog2(LINE_W / 8);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [CNT_W-1:0]  cnt;
    logic [LINE_W-1:0] rbuf;
    logic [LINE_W-1:0] wbuf;
    logic [31:0]       address_q;
    logic              accept;
    logic              final_beat;

    assign accept     = (state == IDLE) && (read_i || write_i);
    assign final_beat = resp_i && (cnt == LAST_BEAT);

    // Next-state: writeback takes priority over fill when both are requested.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (write_i) begin
                    state_next = WRITE;
                end else if (read_i) begin
                    state_next = READ;
                end
            end
            READ, WRITE: begin
                if (final_beat) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Beat counter: cleared while idle, advanced on every memory strobe of a burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
        end else if ((state == READ || state == WRITE) && resp_i) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Request capture: address and writeback data are frozen at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            address_q <= '0;
            wbuf      <= '0;
        end else begin
            if (accept) begin
                address_q <= {address_i[31:OFF_W], {OFF_W{1'b0}}};
            end
            if (state == IDLE && write_i) begin
                wbuf <= line_i;
            end
        end
    end

    // Fill assembly: each read beat lands in its slot of the line buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbuf <= '0;
        end else if (state == READ && resp_i) begin
            rbuf[cnt*BURST_W +: BURST_W] <= burst_i;
        end
    end

    // Outputs decode directly from registered state so the memory side sees no glitches.
    always_comb begin
        read_o    = (state == READ);
        write_o   = (state == WRITE);
        resp_o    = (state == DONE);
        address_o = (state == READ || state == WRITE) ? address_q : '0;
        burst_o   = (state == WRITE) ? wbuf[cnt*BURST_W +: BURST_W] : '0;
    end

    assign line_o = rbuf;

endmodule
